// File: rtl/multi_tick_gen_pkg.sv
// multi_tick_gen_pkg
// Shared constants and helpers for the multi-channel tick generator.
//   TICK_DEF_NUM_CH : default channel count
//   TICK_DEF_CNT_W  : default divisor / counter width
//   TICK_DEF_DIV    : divisor every channel comes out of reset with
//   ch_sel_w()      : width of the channel-select field (never below 1)
package multi_tick_gen_pkg;

    localparam int unsigned TICK_DEF_NUM_CH = 4;
    localparam int unsigned TICK_DEF_CNT_W  = 32;
    localparam int unsigned TICK_DEF_DIV    = 4;

    // A single-channel build still needs a 1-bit select port.
    function automatic int unsigned ch_sel_w(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// tick_channel
// One divider channel: divisor register, up-counter, tick pulse and square wave.
//   clk     : clock, rising edge
//   rst_n   : synchronous active-low reset (div=DEF_DIV, cnt=1, outputs low)
//   sync    : phase restart (cnt=1, tick=0, sq=0), divisor kept
//   en      : count enable; low freezes cnt and sq
//   wr      : load wr_div into the divisor and restart the count
//   wr_div  : new divisor; zero disables the channel
//   tick    : registered one-cycle pulse every div cycles
//   sq      : registered square wave, toggles on every tick
module tick_channel
    import multi_tick_gen_pkg::*;
#(
    parameter int unsigned CNT_W   = TICK_DEF_CNT_W,
    parameter int unsigned DEF_DIV = TICK_DEF_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             tick,
    output logic             sq
);

    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= CNT_W'(DEF_DIV);
            cnt_q <= CNT_W'(1);
            tick  <= 1'b0;
            sq    <= 1'b0;
        end else begin
            if (wr) begin
                div_q <= wr_div;
            end

            // sync wins over the write's restart only in that it also clears sq;
            // the divisor load above still happens when both are present.
            if (sync) begin
                cnt_q <= CNT_W'(1);
                tick  <= 1'b0;
                sq    <= 1'b0;
            end else if (wr) begin
                cnt_q <= CNT_W'(1);
                tick  <= 1'b0;
            end else if (en && (div_q != '0)) begin
                // >= rather than == so a counter somehow above the divisor
                // still wraps instead of running round the full range.
                if (cnt_q >= div_q) begin
                    cnt_q <= CNT_W'(1);
                    tick  <= 1'b1;
                    sq    <= ~sq;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    tick  <= 1'b0;
                end
            end else begin
                tick <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multi_tick_gen.sv
// multi_tick_gen
// NUM_CH independent programmable tick generators sharing one clock.
//   clk     : clock, rising edge
//   rst_n   : synchronous active-low reset, overrides everything
//   sync    : restarts the phase of every channel at once
//   ch_en   : per-channel count enable
//   wr_en   : divisor write strobe
//   wr_ch   : channel addressed by the write; values >= NUM_CH are dropped
//   wr_div  : divisor to write
//   tick    : per-channel one-cycle pulse
//   sq      : per-channel square wave (half the tick rate)
module multi_tick_gen
    import multi_tick_gen_pkg::*;
#(
    parameter int unsigned NUM_CH  = TICK_DEF_NUM_CH,
    parameter int unsigned CNT_W   = TICK_DEF_CNT_W,
    parameter int unsigned DEF_DIV = TICK_DEF_DIV
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sync,
    input  logic [NUM_CH-1:0]             ch_en,
    input  logic                          wr_en,
    input  logic [ch_sel_w(NUM_CH)-1:0]   wr_ch,
    input  logic [CNT_W-1:0]              wr_div,
    output logic [NUM_CH-1:0]             tick,
    output logic [NUM_CH-1:0]             sq
);

    logic [NUM_CH-1:0] wr_sel;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Out-of-range channel numbers match no index, so they are ignored.
        assign wr_sel[i] = wr_en && (32'(wr_ch) == 32'(i));

        tick_channel #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .sync   (sync),
            .en     (ch_en[i]),
            .wr     (wr_sel[i]),
            .wr_div (wr_div),
            .tick   (tick[i]),
            .sq     (sq[i])
        );
    end

endmodule

// File: tb/tb_multi_tick_gen.sv
// tb_multi_tick_gen
// Directed bench for multi_tick_gen: a 4-channel instance plus a 3-channel
// instance that shares the stimulus, so an out-of-range channel write can be seen.
module tb_multi_tick_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sync;
    logic [3:0]  ch_en;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [31:0] wr_div;
    logic [3:0]  tick;
    logic [3:0]  sq;
    logic [2:0]  tick3;
    logic [2:0]  sq3;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    multi_tick_gen #(.NUM_CH(4), .CNT_W(32), .DEF_DIV(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sync   (sync),
        .ch_en  (ch_en),
        .wr_en  (wr_en),
        .wr_ch  (wr_ch),
        .wr_div (wr_div),
        .tick   (tick),
        .sq     (sq)
    );

    multi_tick_gen #(.NUM_CH(3), .CNT_W(32), .DEF_DIV(4)) dut3 (
        .clk    (clk),
        .rst_n  (rst_n),
        .sync   (sync),
        .ch_en  (ch_en[2:0]),
        .wr_en  (wr_en),
        .wr_ch  (wr_ch),
        .wr_div (wr_div),
        .tick   (tick3),
        .sq     (sq3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; return at the following falling edge.
    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        sync   = 1'b0;
        ch_en  = 4'hF;
        wr_en  = 1'b0;
        wr_ch  = 2'd0;
        wr_div = 32'd0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic wr(input logic [1:0] ch, input logic [31:0] d);
        wr_en  = 1'b1;
        wr_ch  = ch;
        wr_div = d;
    endtask

    logic [3:0] e;
    logic [3:0] exp_f [7:14];

    initial begin
        exp_f[7]  = 4'b0000;
        exp_f[8]  = 4'b0001;
        exp_f[9]  = 4'b0010;
        exp_f[10] = 4'b0001;
        exp_f[11] = 4'b0100;
        exp_f[12] = 4'b0011;
        exp_f[13] = 4'b1000;
        exp_f[14] = 4'b0001;

        // Default divisors, all enabled: ticks at 4, 8, 12.
        do_reset();
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_sq", 32'(sq), 32'h0);
        chk("rst_tick3", 32'(tick3), 32'h0);
        for (int c = 1; c <= 12; c++) begin
            step();
            chk($sformatf("A_tick c%0d", c), 32'(tick), (c % 4 == 0) ? 32'hF : 32'h0);
            chk($sformatf("A_sq c%0d", c), 32'(sq), ((c / 4) % 2 == 1) ? 32'hF : 32'h0);
        end

        // ch2 rewritten to 3 on edge 10: ticks 13, 16, 19; others untouched.
        do_reset();
        for (int c = 1; c <= 20; c++) begin
            step();
            e = (c % 4 == 0) ? 4'b1011 : 4'b0000;
            if (c == 4 || c == 8 || c == 13 || c == 16 || c == 19) e[2] = 1'b1;
            chk($sformatf("B_tick c%0d", c), 32'(tick), 32'(e));
            if (c == 12) chk("B_sq c12", 32'(sq), 32'hB);
            if (c == 20) chk("B_sq c20", 32'(sq), 32'hF);
            if (c == 9)  wr(2'd2, 32'd3);
            if (c == 10) wr_en = 1'b0;
        end

        // ch1 disabled on edges 5..7: its ticks slip by three cycles.
        do_reset();
        for (int c = 1; c <= 16; c++) begin
            step();
            e = (c % 4 == 0) ? 4'b1101 : 4'b0000;
            if (c == 4 || c == 11 || c == 15) e[1] = 1'b1;
            chk($sformatf("C_tick c%0d", c), 32'(tick), 32'(e));
            if (c == 7)  chk("C_sq1 c7", 32'(sq[1]), 32'h1);
            if (c == 11) chk("C_sq1 c11", 32'(sq[1]), 32'h0);
            if (c == 15) chk("C_sq1 c15", 32'(sq[1]), 32'h1);
            if (c == 4)  ch_en = 4'b1101;
            if (c == 7)  ch_en = 4'hF;
        end

        // ch0 divisor 0 (silent), then divisor 1 (tick every cycle).
        do_reset();
        wr(2'd0, 32'd0);
        for (int c = 1; c <= 16; c++) begin
            step();
            chk($sformatf("D_tick0 c%0d", c), 32'(tick[0]), (c >= 12) ? 32'h1 : 32'h0);
            if (c == 4)  chk("D_tick_hi c4", 32'(tick[3:1]), 32'h7);
            if (c == 11) chk("D_sq0 c11", 32'(sq[0]), 32'h0);
            if (c == 12) chk("D_sq0 c12", 32'(sq[0]), 32'h1);
            if (c == 13) chk("D_sq0 c13", 32'(sq[0]), 32'h0);
            if (c == 1)  wr_en = 1'b0;
            if (c == 10) wr(2'd0, 32'd1);
            if (c == 11) wr_en = 1'b0;
        end

        // Write to channel 3: real on the 4-channel part, dropped on the 3-channel one.
        do_reset();
        wr(2'd3, 32'd1);
        for (int c = 1; c <= 8; c++) begin
            step();
            chk($sformatf("E_tick3 c%0d", c), 32'(tick3), (c % 4 == 0) ? 32'h7 : 32'h0);
            chk($sformatf("E_tick_ch3 c%0d", c), 32'(tick[3]), (c >= 2) ? 32'h1 : 32'h0);
            chk($sformatf("E_tick_lo c%0d", c), 32'(tick[2:0]), (c % 4 == 0) ? 32'h7 : 32'h0);
            if (c == 1) wr_en = 1'b0;
        end

        // Divisors {2,3,5,7}; sync on edge 6 coincides with the ch3 write.
        do_reset();
        wr(2'd0, 32'd2);
        for (int c = 1; c <= 14; c++) begin
            step();
            if (c == 6) begin
                chk("F_tick c6", 32'(tick), 32'h0);
                chk("F_sq c6", 32'(sq), 32'h0);
            end
            if (c >= 7) chk($sformatf("F_tick c%0d", c), 32'(tick), 32'(exp_f[c]));
            if (c == 9)  chk("F_sq c9", 32'(sq), 32'h3);
            if (c == 13) chk("F_sq c13", 32'(sq), 32'hD);
            if (c == 1) wr(2'd1, 32'd3);
            if (c == 2) wr(2'd2, 32'd5);
            if (c == 3) wr_en = 1'b0;
            if (c == 5) begin
                sync = 1'b1;
                wr(2'd3, 32'd7);
            end
            if (c == 6) begin
                sync  = 1'b0;
                wr_en = 1'b0;
            end
        end

        // Reset mid-period with sync and a write also pending: write is lost.
        do_reset();
        for (int c = 1; c <= 16; c++) begin
            step();
            if (c == 6) chk("G_sq c6", 32'(sq), 32'hF);
            if (c == 7) begin
                chk("G_tick c7", 32'(tick), 32'h0);
                chk("G_sq c7", 32'(sq), 32'h0);
            end
            if (c >= 8) chk($sformatf("G_tick n%0d", c - 7), 32'(tick),
                            ((c - 7) % 4 == 0) ? 32'hF : 32'h0);
            if (c == 6) begin
                rst_n = 1'b0;
                sync  = 1'b1;
                wr(2'd1, 32'd2);
            end
            if (c == 7) begin
                rst_n = 1'b1;
                sync  = 1'b0;
                wr_en = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
